// File: rtl/machine_anode_scan_if.sv
// Display-side bus of machine_anode_scan: shadow load and enable inputs, plus the
// registered anode/segment drive.
interface machine_anode_scan_if;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp;
    logic        enable;
    logic [3:0]  ds;
    logic [6:0]  seg;
    logic        dp_n;
    logic [1:0]  digit;
    logic        tick;

    modport master (
        output value, load, dp, enable,
        input  ds, seg, dp_n, digit, tick
    );

    modport slave (
        input  value, load, dp, enable,
        output ds, seg, dp_n, digit, tick
    );
endinterface

// File: rtl/machine_anode_scan.sv
// 4-digit common-anode seven-segment scan driver with active-low strobes and segments.
// Optional ANODE_SCAN_DEADTIME_EN blanks the anode for the first cycle of every slot.
module machine_anode_scan #(
    parameter int unsigned DIV = 50000
) (
    input logic                 system1000,
    input logic                 system1000_rstn,
    machine_anode_scan_if.slave bus
);

    localparam logic [15:0] PreMax = 16'(DIV - 1);

    logic [15:0] pre_q, pre_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  dp_sh_q, dp_sh_d;
    logic        run_q;
    logic        tick_q, tick_d;
    logic [3:0]  ds_q, ds_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_n_q, dp_n_d;

    function automatic logic [6:0] font(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            pre_q    <= '0;
            digit_q  <= '0;
            shadow_q <= '0;
            dp_sh_q  <= '0;
            run_q    <= 1'b0;
            tick_q   <= 1'b0;
            ds_q     <= 4'hF;
            seg_q    <= 7'h7F;
            dp_n_q   <= 1'b1;
        end else begin
            pre_q    <= pre_d;
            digit_q  <= digit_d;
            shadow_q <= shadow_d;
            dp_sh_q  <= dp_sh_d;
            run_q    <= bus.enable;
            tick_q   <= tick_d;
            ds_q     <= ds_d;
            seg_q    <= seg_d;
            dp_n_q   <= dp_n_d;
        end
    end

    always_comb begin
        pre_d    = pre_q;
        digit_d  = digit_q;
        tick_d   = 1'b0;
        shadow_d = bus.load ? bus.value : shadow_q;
        dp_sh_d  = bus.load ? bus.dp : dp_sh_q;
        // The first enabled edge opens a fresh slot at pre=0 so it lasts a full DIV cycles.
        if (!bus.enable || !run_q) begin
            pre_d = '0;
        end else if (pre_q == PreMax) begin
            pre_d   = '0;
            digit_d = digit_q + 2'd1;
            tick_d  = 1'b1;
        end else begin
            pre_d = pre_q + 16'd1;
        end
    end

    always_comb begin
        ds_d   = 4'hF;
        seg_d  = 7'h7F;
        dp_n_d = 1'b1;
        if (bus.enable) begin
            ds_d   = ~(4'b0001 << digit_d);
            seg_d  = font(shadow_d[{digit_d, 2'b00} +: 4]);
            dp_n_d = ~dp_sh_d[digit_d];
`ifdef ANODE_SCAN_DEADTIME_EN
            if (pre_d == '0) begin
                ds_d = 4'hF;
            end
`endif
        end
    end

    assign bus.ds    = ds_q;
    assign bus.seg   = seg_q;
    assign bus.dp_n  = dp_n_q;
    assign bus.digit = digit_q;
    assign bus.tick  = tick_q;

endmodule

// File: tb/tb_machine_anode_scan.sv
// Directed bench for machine_anode_scan at DIV=4; expectations are hand-written tables.
module tb_machine_anode_scan;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    machine_anode_scan_if bus();

    machine_anode_scan #(.DIV(4)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] ds_tab   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // font of F8A1 indexed by digit: 1, A, 8, F
    logic [6:0] seg_f8a1 [4] = '{7'b1111001, 7'b0001000, 7'b0000000, 7'b0001110};
    // font of 0800 indexed by digit: 0, 0, 8, 0
    logic [6:0] seg_0800 [4] = '{7'b1000000, 7'b1000000, 7'b0000000, 7'b1000000};

    function automatic logic [3:0] exp_ds(input int d, input bit first);
`ifdef ANODE_SCAN_DEADTIME_EN
        if (first) return 4'hF;
`endif
        return ds_tab[d];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.enable = 1'b1; bus.value = 16'h0000; bus.load = 1'b0; bus.dp = 4'h0;
        rstn = 1'b0;
        step(); step();
        n_cmp++; if (bus.ds !== 4'hF) begin n_err++; $display("FAIL reset_ds got %b want 1111", bus.ds); end
        n_cmp++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %b want 1111111", bus.seg); end
        n_cmp++; if (bus.dp_n !== 1'b1) begin n_err++; $display("FAIL reset_dp_n got %b want 1", bus.dp_n); end
        n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got %b want 0", bus.tick); end
        n_cmp++; if (bus.digit !== 2'd0) begin n_err++; $display("FAIL reset_digit got %0d want 0", bus.digit); end
        rstn = 1'b1;
        step();
        n_cmp++; if (bus.ds !== exp_ds(0, 1)) begin n_err++; $display("FAIL release_ds got %b want %b", bus.ds, exp_ds(0, 1)); end
        n_cmp++; if (bus.seg !== 7'b1000000) begin n_err++; $display("FAIL release_seg got %b want 1000000", bus.seg); end
    endtask

    task automatic test_scan();
        bus.enable = 1'b0; bus.load = 1'b1; bus.value = 16'hF8A1;
        step();
        bus.load = 1'b0;
        n_cmp++; if (bus.ds !== 4'hF) begin n_err++; $display("FAIL scan_disabled_ds got %b want 1111", bus.ds); end
        bus.enable = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            int d;
            bit t;
            step();
            d = (i / 4) % 4;
            t = (i % 4 == 0) && (i != 0);
            n_cmp++; if (bus.ds !== exp_ds(d, i % 4 == 0)) begin n_err++; $display("FAIL scan_ds i=%0d got %b want %b", i, bus.ds, exp_ds(d, i % 4 == 0)); end
            n_cmp++; if (bus.seg !== seg_f8a1[d]) begin n_err++; $display("FAIL scan_seg i=%0d got %b want %b", i, bus.seg, seg_f8a1[d]); end
            n_cmp++; if (bus.tick !== t) begin n_err++; $display("FAIL scan_tick i=%0d got %b want %b", i, bus.tick, t); end
            n_cmp++; if (bus.digit !== 2'(d)) begin n_err++; $display("FAIL scan_digit i=%0d got %0d want %0d", i, bus.digit, d); end
        end
    endtask

    // Continues the scan from edge 16 (digit 0, first cycle); edge 24 advances 1 -> 2.
    task automatic test_load_advance();
        for (int i = 17; i < 24; i++) step();
        n_cmp++; if (bus.digit !== 2'd1) begin n_err++; $display("FAIL la_pre_digit got %0d want 1", bus.digit); end
        bus.load = 1'b1; bus.value = 16'h0800;
        step();
        bus.load = 1'b0;
        n_cmp++; if (bus.ds !== exp_ds(2, 1)) begin n_err++; $display("FAIL la_ds got %b want %b", bus.ds, exp_ds(2, 1)); end
        n_cmp++; if (bus.seg !== 7'b0000000) begin n_err++; $display("FAIL la_seg got %b want 0000000", bus.seg); end
        n_cmp++; if (bus.tick !== 1'b1) begin n_err++; $display("FAIL la_tick got %b want 1", bus.tick); end
        n_cmp++; if (bus.digit !== 2'd2) begin n_err++; $display("FAIL la_digit got %0d want 2", bus.digit); end
    endtask

    task automatic test_enable_hold();
        step();
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (bus.ds !== 4'hF) begin n_err++; $display("FAIL hold_ds i=%0d got %b want 1111", i, bus.ds); end
            n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL hold_tick i=%0d got %b want 0", i, bus.tick); end
            n_cmp++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL hold_seg i=%0d got %b want 1111111", i, bus.seg); end
            n_cmp++; if (bus.digit !== 2'd2) begin n_err++; $display("FAIL hold_digit i=%0d got %0d want 2", i, bus.digit); end
        end
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (bus.ds !== exp_ds(2, i == 0)) begin n_err++; $display("FAIL reen_ds i=%0d got %b want %b", i, bus.ds, exp_ds(2, i == 0)); end
            n_cmp++; if (bus.seg !== seg_0800[2]) begin n_err++; $display("FAIL reen_seg i=%0d got %b want %b", i, bus.seg, seg_0800[2]); end
            n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL reen_tick i=%0d got %b want 0", i, bus.tick); end
        end
        step();
        n_cmp++; if (bus.ds !== exp_ds(3, 1)) begin n_err++; $display("FAIL reen_next_ds got %b want %b", bus.ds, exp_ds(3, 1)); end
        n_cmp++; if (bus.seg !== seg_0800[3]) begin n_err++; $display("FAIL reen_next_seg got %b want %b", bus.seg, seg_0800[3]); end
        n_cmp++; if (bus.tick !== 1'b1) begin n_err++; $display("FAIL reen_next_tick got %b want 1", bus.tick); end
    endtask

    // Digit is 3 on entry and held while the new dp mask is loaded.
    task automatic test_dp();
        bus.enable = 1'b0; bus.load = 1'b1; bus.value = 16'hF8A1; bus.dp = 4'b0100;
        step();
        bus.load = 1'b0;
        n_cmp++; if (bus.dp_n !== 1'b1) begin n_err++; $display("FAIL dp_disabled got %b want 1", bus.dp_n); end
        bus.enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            int  d;
            logic e;
            step();
            d = (3 + i / 4) % 4;
            e = (d == 2) ? 1'b0 : 1'b1;
            n_cmp++; if (bus.dp_n !== e) begin n_err++; $display("FAIL dp_n i=%0d got %b want %b", i, bus.dp_n, e); end
            n_cmp++; if (bus.ds !== exp_ds(d, i % 4 == 0)) begin n_err++; $display("FAIL dp_ds i=%0d got %b want %b", i, bus.ds, exp_ds(d, i % 4 == 0)); end
        end
    endtask

    task automatic test_reset_midscan();
        step(); step();
        rstn = 1'b0;
        step();
        n_cmp++; if (bus.ds !== 4'hF) begin n_err++; $display("FAIL mid_ds got %b want 1111", bus.ds); end
        n_cmp++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL mid_seg got %b want 1111111", bus.seg); end
        n_cmp++; if (bus.dp_n !== 1'b1) begin n_err++; $display("FAIL mid_dp_n got %b want 1", bus.dp_n); end
        n_cmp++; if (bus.tick !== 1'b0) begin n_err++; $display("FAIL mid_tick got %b want 0", bus.tick); end
        n_cmp++; if (bus.digit !== 2'd0) begin n_err++; $display("FAIL mid_digit got %0d want 0", bus.digit); end
        rstn = 1'b1;
        step();
        n_cmp++; if (bus.ds !== exp_ds(0, 1)) begin n_err++; $display("FAIL mid_rel_ds got %b want %b", bus.ds, exp_ds(0, 1)); end
        n_cmp++; if (bus.seg !== 7'b1000000) begin n_err++; $display("FAIL mid_rel_seg got %b want 1000000", bus.seg); end
        n_cmp++; if (bus.dp_n !== 1'b1) begin n_err++; $display("FAIL mid_rel_dp_n got %b want 1", bus.dp_n); end
    endtask

    initial begin
        bus.value = 16'h0000; bus.load = 1'b0; bus.dp = 4'h0; bus.enable = 1'b0;
        test_reset();
        test_scan();
        test_load_advance();
        test_enable_hold();
        test_dp();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/machine_anode_scan.md
# machine_anode_scan

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It latches a 16-bit hex value and rotates one active-low anode strobe `ds` through 1110 → 1101 → 1011 → 0111 at a programmable rate. It drives the matching active-low segment pattern for each digit. It is the producer of the `ds` code consumed by the anode-to-index decoder, and it sits between the machine's display register and the board pins.

## Interface
Parameters:
- `DIV`, default 50000: clock cycles per digit slot. Legal range 2..65536; prescaler is 16 bits.

Ports (name, direction, width, meaning):
- `system1000`, in, 1: system clock; all state changes on the rising edge.
- `system1000_rstn`, in, 1: reset, synchronous, active-low.
- `value`, in, 16: hex value to display; nibble k goes to digit k.
- `load`, in, 1: when high, `value` and `dp` are captured into the shadow registers.
- `dp`, in, 4: decimal-point enables per digit, active-high; captured with `load`.
- `enable`, in, 1: scanning enable; when low, the display is blanked and state is held.
- `ds`, out, 4: anode strobes, active-low, one-hot-low.
- `seg`, out, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp_n`, out, 1: decimal point for the active digit, active-low.
- `digit`, out, 2: index of the digit currently selected.
- `tick`, out, 1: one-cycle pulse on each digit advance.

## Operation
- State: 16-bit prescaler `pre`, 2-bit `digit`, 16-bit `shadow`, 4-bit `dp_sh`.
- Reset values (`system1000_rstn` low at an edge):
  - `pre=0`, `digit=0`, `shadow=0`, `dp_sh=0`.
  - `ds=4'b1111`, `seg=7'h7F`, `dp_n=1`, `tick=0`.
- Reset overrides `load` and `enable` in the same cycle.
- Prescaler, when `enable=1`:
  - `pre` counts 0..DIV-1.
  - At `pre==DIV-1`: `pre` wraps to 0, `digit` advances modulo 4 (3 → 0 wraps), and `tick` is 1 for that cycle.
- When `enable=0`:
  - `pre` is held at 0 and `digit` is held; `tick=0`.
  - `ds=1111`, `seg=7F`, `dp_n=1`.
- Load: `load=1` captures `shadow<=value` and `dp_sh<=dp`, regardless of `enable`.
- Outputs are registered and computed from next-state values (`digit_next`, `shadow_next`). There is no extra pipeline stage.
  - `ds = ~(4'b0001 << digit_next)`: digit 0 → 1110, 1 → 1101, 2 → 1011, 3 → 0111.
  - `seg = font(shadow_next[4*digit_next +: 4])`.
  - `dp_n = ~dp_sh_next[digit_next]`.
- Font is full hex 0–F, active-low. Examples:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - A → 7'b0001000
  - F → 7'b0001110
- `ds` never has more than one zero bit.
- Simultaneous `load` and digit advance: the new value is shown on the new digit at the same edge.

## Timing
- Latency from `load` sampled at edge N: `seg`/`dp_n` show the new data after edge N.
- Each digit is active for exactly DIV cycles; a full frame is 4·DIV cycles.
- `enable` 0 → 1 at edge N:
  - After edge N, `ds` selects the held `digit` and `pre` restarts at 0.
  - The first `tick` comes DIV cycles later.
- Reset mid-scan: on the next edge, all outputs return to their reset values. With `enable=1`, scanning restarts at digit 0 one edge later.

## Configuration
- Macro: `ANODE_SCAN_DEADTIME_EN`.
- Defined: during the cycle where `pre_next==0` in every digit slot, `ds=4'b1111` (anti-ghosting gap). `seg`, `dp_n` and `digit` are unaffected, so the anode is low for DIV-1 of every DIV cycles.
- Undefined: there is no gap, and the anode is low for all DIV cycles.

## Test plan
- Reset, with DIV=4 and `enable=1`, `value=16'h0000`:
  - Before release: `ds=1111`, `seg=7F`, `dp_n=1`.
  - After release: `ds=1110`, `seg=7'b1000000`.
- Scan, with `load` of 16'hF8A1 and DIV=4:
  - `ds` sequence 1110/1101/1011/0111, each for 4 cycles.
  - `seg` sequence 1111001, 0001000, 0000000, 0001110.
  - `tick` every 4th cycle; `digit` wraps 3 → 0.
- Load coinciding with an advance from digit 1 → 2, new `value=16'h0800`:
  - The same edge shows `ds=1011`, `seg=7'b0000000`.
- `enable` low for 10 cycles while on digit 2:
  - `ds=1111` and `tick=0` throughout.
  - On re-enable, `ds=1011` for a full 4 cycles.
- `dp=4'b0100`, loaded, scanning: `dp_n=0` only while `ds=1011`.
- With `ANODE_SCAN_DEADTIME_EN` and DIV=4: each slot shows `ds=1111` for 1 cycle and then the digit's strobe for 3 cycles. A reset mid-slot returns all outputs to their reset values on the next edge.
